// File: rtl/fu_issue_arbiter_pkg.sv
// Shared types and constants for the FU issue-port arbiter.
package fu_issue_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_HOLD  = 2'd2,
        ARB_FLUSH = 2'd3
    } arb_state_t;

    localparam int ARB_REQ_ALU = 0;
    localparam int ARB_REQ_LS  = 1;
    localparam int ARB_WAIT_W  = 4;
    localparam int ARB_STAT_W  = 32;

    function automatic logic [ARB_WAIT_W-1:0] sat_inc_wait(
        input logic [ARB_WAIT_W-1:0] val,
        input logic [ARB_WAIT_W-1:0] lim
    );
        return (val >= lim) ? val : val + ARB_WAIT_W'(1);
    endfunction

    function automatic logic [ARB_STAT_W-1:0] sat_inc_stat(input logic [ARB_STAT_W-1:0] val);
        return (&val) ? val : val + ARB_STAT_W'(1);
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Request/grant bundle between the reservation stations and the issue arbiter.
interface fu_issue_arbiter_if #(
    parameter int NUM_REQ      = 2,
    parameter int REQ_IDX_SIZE = 1
);
    logic [NUM_REQ-1:0]      in_req;
    logic [NUM_REQ-1:0]      in_req_multi;
    logic                    in_port_ready;
    logic                    in_done;
    logic                    in_rob_is_mispred;
    logic [NUM_REQ-1:0]      out_gnt;
    logic                    out_gnt_valid;
    logic [REQ_IDX_SIZE-1:0] out_gnt_idx;
    logic                    out_busy;

    modport master (
        output in_req, in_req_multi, in_port_ready, in_done, in_rob_is_mispred,
        input  out_gnt, out_gnt_valid, out_gnt_idx, out_busy
    );

    modport slave (
        input  in_req, in_req_multi, in_port_ready, in_done, in_rob_is_mispred,
        output out_gnt, out_gnt_valid, out_gnt_idx, out_busy
    );
endinterface

// File: rtl/fu_issue_arbiter_rr_priority_pick.sv
// Combinational picker: lowest forced index first, else first request at/after rr_ptr.
module rr_priority_pick #(
    parameter int NUM_REQ      = 2,
    parameter int REQ_IDX_SIZE = 1
) (
    input  logic [NUM_REQ-1:0]      req,
    input  logic [REQ_IDX_SIZE-1:0] rr_ptr,
    input  logic [NUM_REQ-1:0]      forced,
    output logic [NUM_REQ-1:0]      pick,
    output logic                    valid
);
    logic hit_s;
    int   idx_s;

    // Priority search; "valid" doubles as the found-so-far flag
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        hit_s = 1'b0;
        idx_s = 0;
        if (|forced) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s   = forced[i] && !valid;
                pick[i] = hit_s;
                valid   = valid | hit_s;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_s       = (int'(rr_ptr) + k) % NUM_REQ;
                hit_s       = req[idx_s] && !valid;
                pick[idx_s] = hit_s;
                valid       = valid | hit_s;
            end
        end
    end
endmodule

// File: rtl/fu_issue_arbiter.sv
// Issue-port arbiter: registered round-robin grant with starvation override,
// multi-cycle hold and mispredict flush. Optional statistics: ARB_STATS_EN.
module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int REQ_IDX_SIZE = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    fu_issue_arbiter_if.slave    arb
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][ARB_STAT_W-1:0] out_gnt_count,
    output logic [ARB_STAT_W-1:0]              out_conflict_count
`endif
);
    arb_state_t                          state_r, state_next_s;
    logic [REQ_IDX_SIZE-1:0]             rr_ptr_r, pick_idx_s;
    logic [NUM_REQ-1:0][ARB_WAIT_W-1:0]  wait_r;
    logic [NUM_REQ-1:0]                  forced_s, pick_oh_s, gnt_next_s, gnt_r;
    logic [REQ_IDX_SIZE-1:0]             gnt_idx_next_s, gnt_idx_r;
    logic                                pick_valid_s, can_arb_s, busy_next_s;
    logic                                gnt_valid_r, busy_r;

    // A requester is forced only while it still requests and has waited MAX_WAIT
    always_comb begin
        forced_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            forced_s[i] = arb.in_req[i] && (wait_r[i] == ARB_WAIT_W'(MAX_WAIT));
        end
    end

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .REQ_IDX_SIZE(REQ_IDX_SIZE)) u_pick (
        .req    (arb.in_req),
        .rr_ptr (rr_ptr_r),
        .forced (forced_s),
        .pick   (pick_oh_s),
        .valid  (pick_valid_s)
    );

    // Encode the one-hot pick and decide whether a grant issues at this edge
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_idx_s = pick_oh_s[i] ? REQ_IDX_SIZE'(i) : pick_idx_s;
        end
        can_arb_s = ((state_r == ARB_IDLE) || (state_r == ARB_GRANT)) &&
                    arb.in_port_ready && pick_valid_s && !arb.in_rob_is_mispred;
    end

    // State register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a mispredict overrides every other event
    always_comb begin
        state_next_s = state_r;
        if (arb.in_rob_is_mispred) begin
            state_next_s = ARB_FLUSH;
        end else begin
            case (state_r)
                ARB_IDLE, ARB_GRANT: begin
                    if (can_arb_s) begin
                        state_next_s = (|(pick_oh_s & arb.in_req_multi)) ? ARB_HOLD : ARB_GRANT;
                    end else begin
                        state_next_s = ARB_IDLE;
                    end
                end
                ARB_HOLD:  state_next_s = arb.in_done ? ARB_IDLE : ARB_HOLD;
                ARB_FLUSH: state_next_s = ARB_IDLE;
                default:   state_next_s = ARB_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        gnt_next_s     = can_arb_s ? pick_oh_s : '0;
        gnt_idx_next_s = can_arb_s ? pick_idx_s : '0;
        busy_next_s    = (state_r == ARB_HOLD) && !arb.in_done && !arb.in_rob_is_mispred;
    end

    // Output registers and round-robin pointer (pointer survives a flush)
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_idx_r   <= '0;
            busy_r      <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            gnt_r       <= gnt_next_s;
            gnt_valid_r <= can_arb_s;
            gnt_idx_r   <= gnt_idx_next_s;
            busy_r      <= busy_next_s;
            if (can_arb_s) begin
                rr_ptr_r <= (pick_idx_s == REQ_IDX_SIZE'(NUM_REQ - 1)) ? '0
                                                                       : pick_idx_s + REQ_IDX_SIZE'(1);
            end
        end
    end

    // Wait counters: saturate while denied, clear on grant, drop or flush
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wait_r <= '0;
        end else if (arb.in_rob_is_mispred) begin
            wait_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!arb.in_req[i] || gnt_next_s[i]) begin
                    wait_r[i] <= '0;
                end else begin
                    wait_r[i] <= sat_inc_wait(wait_r[i], ARB_WAIT_W'(MAX_WAIT));
                end
            end
        end
    end

    assign arb.out_gnt       = gnt_r;
    assign arb.out_gnt_valid = gnt_valid_r;
    assign arb.out_gnt_idx   = gnt_idx_r;
    assign arb.out_busy      = busy_r;

`ifdef ARB_STATS_EN
    logic [NUM_REQ-1:0][ARB_STAT_W-1:0] gnt_count_r;
    logic [ARB_STAT_W-1:0]              conflict_count_r;
    logic                               conflict_s;

    // Two or more simultaneous requests while the port is ready
    always_comb begin
        conflict_s = 1'b0;
        if (arb.in_port_ready) begin
            conflict_s = ($countones(arb.in_req) > 1);
        end else begin
            conflict_s = 1'b0;
        end
    end

    // Statistics counters: reset only by rst_n, untouched by flush
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            gnt_count_r      <= '0;
            conflict_count_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_next_s[i]) begin
                    gnt_count_r[i] <= sat_inc_stat(gnt_count_r[i]);
                end
            end
            if (conflict_s) begin
                conflict_count_r <= sat_inc_stat(conflict_count_r);
            end
`ifdef DEBUG
            if (can_arb_s) begin
                $display("(ARB) grant %0d", pick_idx_s);
            end
`endif
        end
    end

    assign out_gnt_count      = gnt_count_r;
    assign out_conflict_count = conflict_count_r;
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Self-checking bench for fu_issue_arbiter: vector table plus scoreboard queue.
module tb_fu_issue_arbiter;
    logic clk;
    logic rst_n;

    fu_issue_arbiter_if #(.NUM_REQ(2), .REQ_IDX_SIZE(1)) bus ();

`ifdef ARB_STATS_EN
    logic [1:0][31:0] gnt_count;
    logic [31:0]      conflict_count;
    fu_issue_arbiter #(.NUM_REQ(2), .REQ_IDX_SIZE(1), .MAX_WAIT(4)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .arb(bus),
        .out_gnt_count(gnt_count), .out_conflict_count(conflict_count)
    );
`else
    fu_issue_arbiter #(.NUM_REQ(2), .REQ_IDX_SIZE(1), .MAX_WAIT(4)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .arb(bus)
    );
`endif

    typedef struct {
        logic [1:0] req;
        logic [1:0] multi;
        logic       ready;
        logic       done;
        logic       mis;
        logic [1:0] gnt;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        logic       busy;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_conflicts = 0;
    int   exp_gnt0 = 0;
    int   exp_gnt1 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] req, input logic [1:0] multi, input logic ready,
                       input logic done, input logic mis, input logic [1:0] gnt, input logic busy);
        vec_t v;
        v.req = req; v.multi = multi; v.ready = ready; v.done = done; v.mis = mis;
        v.gnt = gnt; v.busy = busy;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        bus.in_req            = v.req;
        bus.in_req_multi      = v.multi;
        bus.in_port_ready     = v.ready;
        bus.in_done           = v.done;
        bus.in_rob_is_mispred = v.mis;
        e.gnt = v.gnt; e.busy = v.busy; e.name = name;
        exp_q.push_back(e);
        if (v.ready && (v.req == 2'b11)) exp_conflicts++;
        if (v.gnt[0]) exp_gnt0++;
        if (v.gnt[1]) exp_gnt1++;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({got.name, ".gnt"},   32'(bus.out_gnt),       32'(got.gnt));
        check({got.name, ".valid"}, 32'(bus.out_gnt_valid), 32'(|got.gnt));
        check({got.name, ".idx"},   32'(bus.out_gnt_idx),   32'(got.gnt[1]));
        check({got.name, ".busy"},  32'(bus.out_busy),      32'(got.busy));
    endtask

    task automatic check_idle(input string name);
        check({name, ".gnt"},   32'(bus.out_gnt),       32'd0);
        check({name, ".valid"}, 32'(bus.out_gnt_valid), 32'd0);
        check({name, ".idx"},   32'(bus.out_gnt_idx),   32'd0);
        check({name, ".busy"},  32'(bus.out_busy),      32'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] multi, input logic ready,
                                input logic done, input logic mis, input logic [1:0] gnt,
                                input logic busy);
        vec_t v;
        v.req = req; v.multi = multi; v.ready = ready; v.done = done; v.mis = mis;
        v.gnt = gnt; v.busy = busy;
        return v;
    endfunction

    initial begin
        // Round robin, both requesting, single-cycle ops
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // rr_ptr=1 with only req[0]: wrap
        add(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // Starvation: port not ready four cycles, then req[1] beats rr_ptr=0
        for (int i = 0; i < 4; i++) add(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // Multi-cycle hold on req[1], req[0] waits until the cycle after done
        add(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) add(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        add(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        add(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // Mispredict with done during HOLD; rr_ptr=1 must survive the flush
        add(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        add(2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        // Mispredict in IDLE beats a new request
        add(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);

        rst_n = 1'b0;
        bus.in_req = 2'b00; bus.in_req_multi = 2'b00; bus.in_port_ready = 1'b0;
        bus.in_done = 1'b0; bus.in_rob_is_mispred = 1'b0;
        #1;
        check_idle("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-HOLD clears outputs without a clock edge
        apply(mk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0), "hold_gnt");
        apply(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1), "hold_busy");
        #2;
        rst_n = 1'b0;
        exp_conflicts = 0; exp_gnt0 = 0; exp_gnt1 = 0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0), "post_rst");
        apply(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0), "post_rst_idle");

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

`ifdef ARB_STATS_EN
        check("conflict_count", conflict_count, 32'(exp_conflicts));
        check("gnt_count0",     gnt_count[0],   32'(exp_gnt0));
        check("gnt_count1",     gnt_count[1],   32'(exp_gnt1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
